// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: queues cache line-fill requests and fetches each line from a
// memory port as four 32-bit beats. It then hands the assembled 128-bit line
// back to the cache.
//
// Ports
//   clk_i, rst_i      single clock; asynchronous active-high reset
//   rqst_i            one-cycle fill request from the cache lookup stage
//   rqst_addr_i       byte address of the miss; bits [19:4] select the line
//   rqst_busy_o       queue full: a request presented now is not accepted
//   overflow_o        sticky: a non-duplicate request was lost to a full queue
//   mem_req_valid_o   memory read request valid (only while in REQ)
//   mem_req_addr_o    line-aligned read address
//   mem_req_ready_i   memory accepts the read request
//   mem_rsp_valid_i   one response beat valid
//   mem_rsp_data_i    response beat data, lowest word first
//   fill_valid_o      one-cycle pulse: line complete
//   fill_addr_o       filled line address; held until the next fill
//   fill_data_o       assembled line data; held outside a transfer
module mem_fill_ctrl #(
    parameter int DEPTH = 2  // request queue entries, 2 or 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rqst_i,
    input  logic [19:0]  rqst_addr_i,
    output logic         rqst_busy_o,
    output logic         overflow_o,
    output logic         mem_req_valid_o,
    output logic [19:0]  mem_req_addr_o,
    input  logic         mem_req_ready_i,
    input  logic         mem_rsp_valid_i,
    input  logic [31:0]  mem_rsp_data_i,
    output logic         fill_valid_o,
    output logic [19:0]  fill_addr_o,
    output logic [127:0] fill_data_o
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RSP, FILL} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   tags [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [15:0]   line;        // in-flight line tag
    logic [1:0]    beat;        // index of the next response beat
    logic [15:0]   rqst_line;
    logic          full;
    logic          dup;
    logic          push;
    logic          pop;

    assign rqst_line = rqst_addr_i[19:4];
    assign full      = (count == FULL_CNT);

    // A request is a duplicate when its line is already queued or being fetched.
    // In IDLE the head entry is still counted in the queue on its pop edge,
    // so the queue scan alone covers that edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        dup = (state != IDLE) && (line == rqst_line);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) && tags[rd_ptr + PW'(i)] == rqst_line) begin
                dup = 1'b1;
            end
        end
    end

    // Acceptance depends only on the count at the edge. A pop on the same edge
    // does not free space for the request.
    assign push = rqst_i && !full && !dup;
    assign pop  = (state == IDLE) && (count != '0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pop) state_nxt = REQ;
            REQ:  if (mem_req_ready_i) state_nxt = RSP;
            RSP:  if (mem_rsp_valid_i && beat == 2'd3) state_nxt = FILL;
            FILL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the tag storage has no reset; an entry is only read after count shows it was written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tags[wr_ptr] <= rqst_line;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            line        <= '0;
            beat        <= '0;
            overflow_o  <= 1'b0;
            fill_addr_o <= '0;
            fill_data_o <= '0;
        end else begin
            state <= state_nxt;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                line   <= tags[rd_ptr];
            end
            if (rqst_i && full && !dup) begin
                overflow_o <= 1'b1;
            end
            if (state == REQ && mem_req_ready_i) begin
                beat <= '0;
            end
            // Beats land directly in their slot. Beats outside RSP never reach here.
            if (state == RSP && mem_rsp_valid_i) begin
                fill_data_o[{beat, 5'd0} +: 32] <= mem_rsp_data_i;
                beat <= beat + 1'b1;
                if (beat == 2'd3) begin
                    fill_addr_o <= {line, 4'b0000};
                end
            end
        end
    end

    assign rqst_busy_o     = full;
    assign mem_req_valid_o = (state == REQ);
    assign mem_req_addr_o  = {line, 4'b0000};
    assign fill_valid_o    = (state == FILL);

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Testbench for mem_fill_ctrl.
//
// The model tracks outstanding lines (queued or in flight) in arrival order.
// The stimulus process decides whether each request is accepted, dropped or
// overflowed, acts as the memory, and pushes each expected fill into a
// scoreboard queue. A separate monitor pops that queue on every fill pulse.
module tb_mem_fill_ctrl;

    localparam int DEPTH = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         rqst_i;
    logic [19:0]  rqst_addr_i;
    logic         rqst_busy_o;
    logic         overflow_o;
    logic         mem_req_valid_o;
    logic [19:0]  mem_req_addr_o;
    logic         mem_req_ready_i;
    logic         mem_rsp_valid_i;
    logic [31:0]  mem_rsp_data_i;
    logic         fill_valid_o;
    logic [19:0]  fill_addr_o;
    logic [127:0] fill_data_o;

    mem_fill_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .rqst_i          (rqst_i),
        .rqst_addr_i     (rqst_addr_i),
        .rqst_busy_o     (rqst_busy_o),
        .overflow_o      (overflow_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .fill_valid_o    (fill_valid_o),
        .fill_addr_o     (fill_addr_o),
        .fill_data_o     (fill_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0]  line;
        logic [127:0] data;
    } fill_t;

    int           checks = 0;
    int           errors = 0;
    logic [15:0]  outstanding[$];  // accepted lines not yet filled, oldest first
    fill_t        exp_fill[$];
    bit           ph_rsp;          // memory is returning beats
    int           beat_idx;
    logic [127:0] cur_data;
    logic [19:0]  last_addr;
    logic [127:0] last_data;
    bit           ovf_model;
    bit           drop_pending;
    int           ready_pct, beat_pct, stray_pct;
    bit           fixed_beats;
    int           exp_valid_steps;
    int           req_cnt;
    int           fill_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every fill pulse must match the oldest expected fill.
    always @(negedge clk_i) begin
        if (!rst_i && fill_valid_o) begin
            fill_t e;
            fill_cnt++;
            check("fill_expected", exp_fill.size() != 0, 1'b1);
            if (exp_fill.size() != 0) begin
                e = exp_fill.pop_front();
                check("fill_addr", fill_addr_o, {e.line, 4'h0});
                check("fill_data", fill_data_o, e.data);
            end
        end
    end

    task automatic clear_model();
        outstanding.delete();
        exp_fill.delete();
        ph_rsp = 0; beat_idx = 0; cur_data = '0;
        last_addr = '0; last_data = '0;
        ovf_model = 0; drop_pending = 0; exp_valid_steps = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        rqst_i = 1'b0; rqst_addr_i = '0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        #1;
        check("rst_busy", rqst_busy_o, 1'b0);
        check("rst_overflow", overflow_o, 1'b0);
        check("rst_req_valid", mem_req_valid_o, 1'b0);
        check("rst_req_addr", mem_req_addr_o, 20'h0);
        check("rst_fill_valid", fill_valid_o, 1'b0);
        check("rst_fill_addr", fill_addr_o, 20'h0);
        check("rst_fill_data", fill_data_o, 128'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_model();
    endtask

    // One clock cycle: observe outputs at the falling edge, check them against
    // the model, then drive request and memory-side inputs.
    task automatic step(input bit rq, input logic [19:0] a);
        bit          in_flight, full, dup, rdy, bv;
        int          cnt;
        logic [15:0] ln;
        logic [31:0] d;
        @(negedge clk_i);
        if (drop_pending) void'(outstanding.pop_front());
        drop_pending = fill_valid_o;
        in_flight = mem_req_valid_o || ph_rsp || fill_valid_o;
        cnt  = outstanding.size() - (in_flight ? 1 : 0);
        full = (cnt == DEPTH);
        check("busy", rqst_busy_o, full);
        check("overflow", overflow_o, ovf_model);
        if (!ph_rsp) begin
            check("fill_addr_hold", fill_addr_o, last_addr);
            check("fill_data_hold", fill_data_o, last_data);
        end
        if (exp_valid_steps > 0) begin
            check("req_valid_expected", mem_req_valid_o, 1'b1);
            exp_valid_steps--;
        end
        // memory request side
        rdy = ($urandom_range(99) < ready_pct);
        mem_req_ready_i = rdy;
        if (mem_req_valid_o) begin
            check("req_has_line", outstanding.size() != 0, 1'b1);
            if (outstanding.size() != 0) check("req_addr", mem_req_addr_o, {outstanding[0], 4'h0});
        end
        // memory response side
        bv = 1'b0;
        d  = $urandom;
        if (ph_rsp) begin
            if ($urandom_range(99) < beat_pct) begin
                bv = 1'b1;
                if (fixed_beats) d = 32'hA0 + 32'(beat_idx);
                cur_data[beat_idx*32 +: 32] = d;
                beat_idx++;
                if (beat_idx == 4) begin
                    if (outstanding.size() != 0) begin
                        exp_fill.push_back('{line: outstanding[0], data: cur_data});
                        last_addr = {outstanding[0], 4'h0};
                    end
                    last_data = cur_data;
                    ph_rsp = 0;
                end
            end
        end else begin
            bv = ($urandom_range(99) < stray_pct);
        end
        mem_rsp_valid_i = bv;
        mem_rsp_data_i  = d;
        if (mem_req_valid_o && rdy) begin
            req_cnt++;
            ph_rsp = 1;
            beat_idx = 0;
        end
        // request side
        rqst_i = rq;
        rqst_addr_i = a;
        if (rq) begin
            ln  = a[19:4];
            dup = 0;
            foreach (outstanding[i]) if (outstanding[i] == ln) dup = 1;
            if (!dup) begin
                if (full) ovf_model = 1;
                else outstanding.push_back(ln);
            end
        end
    endtask

    task automatic drain(input int max_steps);
        for (int i = 0; i < max_steps; i++) begin
            if (outstanding.size() == 0 && !drop_pending && !ph_rsp) break;
            step(1'b0, 20'h0);
        end
        check("drain_done", outstanding.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, f0;
        req_cnt = 0; fill_cnt = 0;
        clear_model();
        rst_i = 1'b1;
        rqst_i = 1'b0; rqst_addr_i = '0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        @(negedge clk_i);
        do_reset();

        // Single miss with fixed beats A0..A3, memory always ready
        ready_pct = 100; beat_pct = 100; stray_pct = 0; fixed_beats = 1;
        step(1'b1, 20'h1234C);
        step(1'b0, 20'h0);
        exp_valid_steps = 1;
        drain(50);
        check("single_req_count", req_cnt, 1);
        check("single_fill_count", fill_cnt, 1);
        check("single_fill_addr", fill_addr_o, 20'h12340);
        check("single_fill_data", fill_data_o, 128'h000000A3_000000A2_000000A1_000000A0);

        // Backpressure: ready low for 5 cycles
        r0 = req_cnt; f0 = fill_cnt;
        ready_pct = 0;
        step(1'b1, 20'h2A5F0);
        step(1'b0, 20'h0);
        exp_valid_steps = 5;
        repeat (5) step(1'b0, 20'h0);
        ready_pct = 100;
        drain(50);
        check("bp_req_count", req_cnt - r0, 1);
        check("bp_fill_count", fill_cnt - f0, 1);

        // Duplicate line back to back
        r0 = req_cnt; f0 = fill_cnt;
        step(1'b1, 20'h50004);
        step(1'b1, 20'h5000C);
        drain(50);
        check("dup_req_count", req_cnt - r0, 1);
        check("dup_fill_count", fill_cnt - f0, 1);
        check("dup_fill_addr", fill_addr_o, 20'h50000);
        check("dup_overflow", overflow_o, 1'b0);

        // Stray beats while idle
        f0 = fill_cnt;
        stray_pct = 100;
        repeat (6) step(1'b0, 20'h0);
        stray_pct = 0;
        check("stray_no_fill", fill_cnt - f0, 0);
        check("stray_req_valid", mem_req_valid_o, 1'b0);
        check("stray_data_hold", fill_data_o, 128'h000000A3_000000A2_000000A1_000000A0);

        // Reset after two beats of a transfer
        fixed_beats = 0;
        step(1'b1, 20'h7777C);
        repeat (4) step(1'b0, 20'h0);
        check("mid_rsp_beats", beat_idx, 2);
        f0 = fill_cnt;
        do_reset();
        stray_pct = 100;
        repeat (6) step(1'b0, 20'h0);
        stray_pct = 0;
        check("rst_no_fill", fill_cnt - f0, 0);
        step(1'b1, 20'h7777C);
        step(1'b0, 20'h0);
        exp_valid_steps = 1;
        drain(50);
        check("post_rst_fill_count", fill_cnt - f0, 1);
        check("post_rst_fill_addr", fill_addr_o, 20'h77770);

        // Queue full: one stalled in flight, two queued, a fourth is lost
        f0 = fill_cnt;
        ready_pct = 0;
        step(1'b1, 20'h11110);
        step(1'b0, 20'h0);
        step(1'b0, 20'h0);
        step(1'b1, 20'h22220);
        step(1'b1, 20'h33330);
        @(posedge clk_i); #1;
        check("full_busy", rqst_busy_o, 1'b1);
        step(1'b1, 20'h44440);
        @(posedge clk_i); #1;
        check("full_overflow", overflow_o, 1'b1);
        ready_pct = 100;
        drain(100);
        check("full_fill_count", fill_cnt - f0, 3);
        check("full_fill_last", fill_addr_o, 20'h33330);
        check("full_overflow_sticky", overflow_o, 1'b1);

        // Randomized traffic
        do_reset();
        ready_pct = 60; beat_pct = 70; stray_pct = 30;
        for (int i = 0; i < 500; i++) begin
            logic [15:0] ln;
            logic [3:0]  lo;
            ln = 16'h0A00 + 16'($urandom_range(5));
            lo = 4'($urandom);
            step($urandom_range(99) < 30, {ln, lo});
        end
        ready_pct = 100; beat_pct = 100; stray_pct = 0;
        drain(200);
        step(1'b0, 20'h0);
        check("leftover_fills", exp_fill.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 Parameter: DEPTH, 2, number of request-queue entries; legal values 2 or 4.
REQ-002 Port: clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_i  in  1  asynchronous, active-high reset.
REQ-004 Port: rqst_i  in  1  line-fill request from the cache lookup stage (its rqst_to_mem_o); one-cycle pulse.
REQ-005 Port: rqst_addr_i  in  20  byte address of the missing access (the cache's addr_to_mem_o).
REQ-006 Port: rqst_busy_o  out  1  queue full; a request presented now is not accepted.
REQ-007 Port: overflow_o  out  1  sticky flag: a request was lost because the queue was full.
REQ-008 Port: mem_req_valid_o  out  1  memory read request valid.
REQ-009 Port: mem_req_addr_o  out  20  line-aligned read address {line[19:4], 4'b0000}.
REQ-010 Port: mem_req_ready_i  in  1  memory accepts the request when it and mem_req_valid_o are both high.
REQ-011 Port: mem_rsp_valid_i  in  1  one 32-bit response beat valid.
REQ-012 Port: mem_rsp_data_i  in  32  response beat data.
REQ-013 Port: fill_valid_o  out  1  one-cycle pulse: line complete (drives the cache's mem_data_ready_i).
REQ-014 Port: fill_addr_o  out  20  filled line address {line, 4'b0000} (drives the cache's mem_addr_i).
REQ-015 Port: fill_data_o  out  128  assembled line data.

Function
REQ-016 The block SHALL hold request line tags (rqst_addr_i[19:4]) in a FIFO of DEPTH entries, in arrival order.
REQ-017 A request SHALL be accepted iff rqst_i=1 and the entry count < DEPTH at that edge; this holds even if a pop occurs on the same edge.
REQ-018 A request SHALL be silently dropped, without setting overflow_o, if its line equals any valid FIFO entry or the in-flight line (state != IDLE).
REQ-019 If rqst_i=1 while the queue is full and the request is not a duplicate, overflow_o SHALL set and stay at 1 until reset.
REQ-020 rqst_busy_o SHALL be 1 exactly when count == DEPTH.
REQ-021 The FSM SHALL have four states: IDLE, REQ, RSP, FILL.
REQ-022 IDLE with FIFO non-empty: pop the head into the in-flight line register and go to REQ; otherwise stay in IDLE.
REQ-023 In REQ, mem_req_valid_o SHALL be 1 with mem_req_addr_o stable. When mem_req_ready_i=1: clear the beat counter and go to RSP.
REQ-024 In RSP, each cycle with mem_rsp_valid_i=1 SHALL write mem_rsp_data_i to fill_data_o bits [32k+31:32k], where k is the beat counter (0..3), then increment k.
REQ-025 On the 4th beat the FSM SHALL go to FILL.
REQ-026 mem_rsp_valid_i outside RSP SHALL be ignored.
REQ-027 In FILL: fill_valid_o=1 for exactly one cycle, fill_addr_o = {in-flight line, 4'b0000}; the next state is IDLE.
REQ-028 fill_addr_o and fill_data_o SHALL hold their values until the next fill.
REQ-029 Latency: a request accepted on edge N into an empty queue with the FSM in IDLE SHALL give mem_req_valid_o=1 in the cycle after edge N+1.
REQ-030 fill_valid_o SHALL assert in the cycle after the edge that samples the 4th beat.
REQ-031 Only one memory read SHALL be outstanding at a time; mem_req_valid_o SHALL be 0 in every state except REQ.
REQ-032 All outputs SHALL be registered or decoded from registered state only; there is no combinational path from inputs to outputs.

Reset
REQ-033 rst_i=1 SHALL immediately force state IDLE, FIFO empty, beat counter 0, overflow_o=0, rqst_busy_o=0, mem_req_valid_o=0, fill_valid_o=0, mem_req_addr_o=0, fill_addr_o=0, fill_data_o=0.
REQ-034 Reset mid-transfer SHALL discard the in-flight line; no fill SHALL be produced for it, and beats arriving after reset release SHALL be ignored.

Verification
REQ-035 Single miss: rqst_i at edge 0, addr 0x1234C; ready tied 1; beats 0xA0,0xA1,0xA2,0xA3 -> mem_req_addr_o=0x12340 in cycle 2; one fill_valid_o pulse with fill_addr_o=0x12340 and fill_data_o=0x000000A3_000000A2_000000A1_000000A0.
REQ-036 Backpressure: mem_req_ready_i held 0 for 5 cycles -> mem_req_valid_o=1 and the address constant for all 5 cycles; exactly one request is accepted.
REQ-037 Queue full (DEPTH=2): 3 distinct-line requests while the first is stalled -> 1 in flight plus 1 queued; the 3rd arrives with rqst_busy_o=0 and is accepted; a 4th sees rqst_busy_o=1, overflow_o=1, and yields no fill; exactly 3 fills, in order.
REQ-038 Duplicate: requests 0x50004 and 0x5000C back to back -> exactly one memory request and one fill (line 0x5000); overflow_o=0.
REQ-039 Reset mid-RSP: rst_i pulsed after 2 beats -> all outputs 0 at once; no fill follows; the next request completes normally.
REQ-040 Stray beats: mem_rsp_valid_i pulsed while in IDLE -> no state change, fill_data_o unchanged.
